// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_arb_pkg
// Description : Shared definitions for the ALU arbiter: opcode encodings and
//               the three-state scheduler FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_arb_pkg;

    // 3-bit ALU opcodes
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_LSL = 3'b110;
    localparam logic [2:0] OP_LSR = 3'b111;

    // Scheduler states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : alu_arb_pkg
`default_nettype wire

// File: rtl/alu4_core.sv
`default_nettype none
// ============================================================================
// Module      : alu4_core
// Description : Purely combinational 4-bit ALU.
//               Ports: i_a, i_b (operands), i_op (opcode),
//                      o_result (4-bit result), o_carry (carry / no-borrow).
// Revision    : 1.0 - initial release
// ============================================================================
module alu4_core
    import alu_arb_pkg::*;
(
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic [2:0] i_op,
    output logic [3:0] o_result,
    output logic       o_carry
);

    always_comb begin
        o_result = 4'd0;
        o_carry  = 1'b0;
        case (i_op)
            OP_ADD: {o_carry, o_result} = {1'b0, i_a} + {1'b0, i_b};
            // Two's-complement subtract; carry out high means a >= b.
            OP_SUB: {o_carry, o_result} = {1'b0, i_a} + {1'b0, ~i_b} + 5'd1;
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_XOR: o_result = i_a ^ i_b;
            OP_NOT: o_result = ~i_a;
            OP_LSL: o_result = i_a << i_b[1:0];
            OP_LSR: o_result = i_a >> i_b[1:0];
            default: begin
                o_result = 4'd0;
                o_carry  = 1'b0;
            end
        endcase
    end

endmodule : alu4_core
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin scheduler sharing one registered 4-bit ALU among
//               NREQ requesters. One op in flight at a time: grant (IDLE),
//               compute (EXEC), respond with backpressure (RESP).
//               Ports: clk, rst (async, active-high)
//                      req_valid/req_ready/req_a/req_b/req_op - request side
//                      rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_carry
//                      stat_cnt - per-requester 8-bit saturating completion
//                                 counters, present only when the macro
//                                 ALU_ARB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [4*NREQ-1:0]   req_a,
    input  logic [4*NREQ-1:0]   req_b,
    input  logic [3*NREQ-1:0]   req_op,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [3:0]          rsp_result,
    output logic                rsp_carry
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [8*NREQ-1:0]   stat_cnt
`endif
);

    localparam logic [IDW:0]   C_NREQ = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] C_LAST = IDW'(NREQ - 1);

    state_t          r_state;
    state_t          w_next;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_id;
    logic [IDW-1:0]  r_rsp_id;
    logic [3:0]      r_a;
    logic [3:0]      r_b;
    logic [2:0]      r_op;
    logic [3:0]      r_result;
    logic            r_carry;
    logic            r_rsp_valid;

    logic [NREQ-1:0] w_rot;
    logic [IDW:0]    w_sum;
    logic            w_any;
    logic [IDW-1:0]  w_win_id;
    logic [3:0]      w_sel_a;
    logic [3:0]      w_sel_b;
    logic [2:0]      w_sel_op;
    logic [3:0]      w_alu_result;
    logic            w_alu_carry;
    logic            w_rsp_hs;
    logic [IDW-1:0]  w_ptr_next;

    // ------------------------------------------------------------------
    // Round-robin pick: rotate valids so rr_ptr sits at bit 0, take the
    // lowest set bit, then map the offset back to an absolute index.
    // ------------------------------------------------------------------
    always_comb begin
        w_rot    = NREQ'({req_valid, req_valid} >> r_rr_ptr);
        w_any    = 1'b0;
        w_win_id = '0;
        w_sum    = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_any && w_rot[k]) begin
                w_any = 1'b1;
                w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
                if (w_sum >= C_NREQ) begin
                    w_sum = w_sum - C_NREQ;
                end
                w_win_id = w_sum[IDW-1:0];
            end
        end
    end

    // Operand mux for the winning requester
    always_comb begin
        w_sel_a  = 4'd0;
        w_sel_b  = 4'd0;
        w_sel_op = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win_id == IDW'(i)) begin
                w_sel_a  = req_a[4*i +: 4];
                w_sel_b  = req_b[4*i +: 4];
                w_sel_op = req_op[3*i +: 3];
            end
        end
    end

    assign w_rsp_hs   = (r_state == RESP) && rsp_ready;
    assign w_ptr_next = (r_rsp_id == C_LAST) ? '0 : r_rsp_id + IDW'(1);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    req_ready[w_win_id] = 1'b1;
                    w_next              = EXEC;
                end
            end
            EXEC: w_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shared ALU, fed only from the captured operands
    // ------------------------------------------------------------------
    alu4_core u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (r_op),
        .o_result (w_alu_result),
        .o_carry  (w_alu_carry)
    );

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_a         <= 4'd0;
            r_b         <= 4'd0;
            r_op        <= 3'd0;
            r_result    <= 4'd0;
            r_carry     <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_a  <= w_sel_a;
                        r_b  <= w_sel_b;
                        r_op <= w_sel_op;
                        r_id <= w_win_id;
                    end
                end
                EXEC: begin
                    r_result    <= w_alu_result;
                    r_carry     <= w_alu_carry;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                end
                RESP: begin
                    // Pointer only moves on handshake so a stalled response
                    // does not disturb fairness.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rr_ptr    <= w_ptr_next;
                    end
                end
                default: r_rsp_valid <= 1'b0;
            endcase
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_result;
    assign rsp_carry  = r_carry;

`ifdef ALU_ARB_STATS_EN
    // Per-requester completion counters, saturating at 255
    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        logic [7:0] r_cnt;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= 8'd0;
            end else if (w_rsp_hs && (r_rsp_id == IDW'(g)) && (r_cnt != 8'hFF)) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
        assign stat_cnt[8*g +: 8] = r_cnt;
    end
`else
    logic w_unused_hs;
    assign w_unused_hs = w_rsp_hs;
`endif

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter. A monitor pushes the
//               expected response to a scoreboard at each grant and pops it
//               on each response handshake; directed sequences cover
//               round-robin order, throughput, backpressure and reset.
//               Stat counter checks are compiled when ALU_ARB_STATS_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_a = '0;
    logic [4*NREQ-1:0] req_b = '0;
    logic [3*NREQ-1:0] req_op = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [IDW-1:0]    rsp_id;
    logic [3:0]        rsp_result;
    logic              rsp_carry;
`ifdef ALU_ARB_STATS_EN
    logic [8*NREQ-1:0] stat_cnt;
`endif

    alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry)
`ifdef ALU_ARB_STATS_EN
        ,
        .stat_cnt   (stat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference ALU: {carry, result}
    function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
        int ia, ib, r, sh;
        logic c;
        ia = int'(a);
        ib = int'(b);
        sh = int'(b[1:0]);
        c  = 1'b0;
        r  = 0;
        case (op)
            3'd0: begin r = ia + ib; c = (r > 15); end
            3'd1: begin r = ia - ib; c = (ia >= ib); end
            3'd2: r = ia & ib;
            3'd3: r = ia | ib;
            3'd4: r = ia ^ ib;
            3'd5: r = 15 - ia;
            3'd6: r = ia * (1 << sh);
            default: r = ia / (1 << sh);
        endcase
        return {c, 4'(r & 15)};
    endfunction

    function automatic int idx_of(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return 0;
    endfunction

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    logic [6:0] sb[$];
    int         glog[$];
    int         hs_log[$];
    int         cyc = 0;
    int         grant_cyc = 0;
    logic [6:0] last_rsp = '0;
    logic       prev_v = 1'b0;
    logic       prev_r = 1'b0;
    logic [6:0] prev_out = '0;

    always @(negedge clk) begin
        int         gid;
        logic [6:0] exp_e;
        cyc++;
        if (rst) begin
            sb.delete();
            prev_v = 1'b0;
        end else begin
            if (req_ready != '0) begin
                gid = idx_of(req_ready);
                check("grant_onehot", 32'($onehot(req_ready)), 1);
                check("grant_valid", 32'(req_valid[gid]), 1);
                check("grant_while_rsp", 32'(rsp_valid), 0);
                sb.push_back({2'(gid), model(req_a[4*gid +: 4], req_b[4*gid +: 4],
                                              req_op[3*gid +: 3])});
                glog.push_back(gid);
                grant_cyc = cyc;
            end
            if (rsp_valid && !prev_v) begin
                check("rsp_latency", 32'(cyc - grant_cyc), 2);
            end
            if (rsp_valid && prev_v && !prev_r) begin
                check("stall_hold", {25'd0, rsp_id, rsp_carry, rsp_result}, {25'd0, prev_out});
                check("stall_no_ready", 32'(req_ready), 0);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    exp_e = sb.pop_front();
                    check("rsp", {25'd0, rsp_id, rsp_carry, rsp_result}, {25'd0, exp_e});
                end
                last_rsp = {rsp_id, rsp_carry, rsp_result};
                hs_log.push_back(cyc);
            end
            prev_v   = rsp_valid;
            prev_r   = rsp_ready;
            prev_out = {rsp_id, rsp_carry, rsp_result};
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_req(input int id, input logic [3:0] a, input logic [3:0] b,
                           input logic [2:0] op);
        req_a[4*id +: 4]  = a;
        req_b[4*id +: 4]  = b;
        req_op[3*id +: 3] = op;
    endtask

    // Returns at #1 after the grant edge (DUT then in EXEC)
    task automatic wait_grant(input int id);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready[id] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("grant_timeout", 32'(req_ready[id]), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int id, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] op);
        set_req(id, a, b, op);
        req_valid[id] = 1'b1;
        wait_grant(id);
        req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int         id;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] res;
        logic       c;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int got;
        int budget;
        int gid;
        int cnt;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_result", 32'(rsp_result), 0);
        check("rst_rsp_carry", 32'(rsp_carry), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ---------------- all requesters continuously valid ----------------
        glog.delete();
        hs_log.delete();
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)));
        end
        req_valid = '1;
        got    = 0;
        budget = 100;
        while (got < 5 && budget > 0) begin
            @(negedge clk);
            budget--;
            if (req_ready != '0) begin
                gid = idx_of(req_ready);
                @(posedge clk);
                #1;
                got++;
                if (got == 5) req_valid = '0;
                else set_req(gid, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                             3'($urandom_range(0, 7)));
            end
        end
        check("stream_grants", 32'(got), 5);
        drain();
        for (int i = 0; i < 5; i++) begin
            check("rr_order", (i < glog.size()) ? 32'(glog[i]) : 32'hFFFF, 32'(i % NREQ));
        end
        for (int i = 1; i < 5; i++) begin
            check("throughput", (i < hs_log.size()) ? 32'(hs_log[i] - hs_log[i-1]) : 0, 3);
        end

        // ---------------- directed opcodes with known answers ----------------
        vecs.push_back('{1, 4'd9,  4'd8,  OP_ADD, 4'd1,  1'b1});
        vecs.push_back('{0, 4'd3,  4'd5,  OP_SUB, 4'd14, 1'b0});
        vecs.push_back('{2, 4'd5,  4'd3,  OP_SUB, 4'd2,  1'b1});
        vecs.push_back('{3, 4'd7,  4'd2,  OP_LSL, 4'd12, 1'b0});
        vecs.push_back('{1, 4'd8,  4'd3,  OP_LSR, 4'd1,  1'b0});
        vecs.push_back('{2, 4'd10, 4'd0,  OP_NOT, 4'd5,  1'b0});
        vecs.push_back('{0, 4'd12, 4'd10, OP_AND, 4'd8,  1'b0});
        vecs.push_back('{3, 4'd12, 4'd10, OP_OR,  4'd14, 1'b0});
        vecs.push_back('{1, 4'd12, 4'd10, OP_XOR, 4'd6,  1'b0});
        vecs.push_back('{0, 4'd15, 4'd1,  OP_ADD, 4'd0,  1'b1});
        foreach (vecs[k]) begin
            send(vecs[k].id, vecs[k].a, vecs[k].b, vecs[k].op);
            drain();
            check("known_answer", {25'd0, last_rsp},
                  {25'd0, 2'(vecs[k].id), vecs[k].c, vecs[k].res});
        end

        // ---------------- random single ops ----------------
        for (int k = 0; k < 16; k++) begin
            send($urandom_range(0, NREQ - 1), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
            drain();
        end

        // ---------------- backpressure ----------------
        rsp_ready = 1'b0;
        send(3, 4'd6, 4'd7, OP_ADD);
        budget = 0;
        while (!rsp_valid && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("bp_rsp_seen", 32'(rsp_valid), 1);
        set_req(0, 4'd9, 4'd4, OP_SUB);
        req_valid[0] = 1'b1;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        check("bp_still_valid", 32'(rsp_valid), 1);
        check("bp_no_ready", 32'(req_ready), 0);
        check("bp_out", {25'd0, rsp_id, rsp_carry, rsp_result}, {25'd0, 2'd3, 1'b0, 4'd13});
        rsp_ready = 1'b1;
        wait_grant(0);
        req_valid[0] = 1'b0;
        check("grant_after_hs", 32'(grant_cyc - hs_log[$]), 1);
        drain();

        // ---------------- reset during EXEC ----------------
        send(2, 4'd15, 4'd15, OP_ADD);
        #2;
        rst = 1'b1;
        #1;
        check("arst_rsp_valid", 32'(rsp_valid), 0);
        check("arst_rsp_out", {28'd0, rsp_id, rsp_carry, rsp_result} & 32'h7F, 0);
        check("arst_req_ready", 32'(req_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        check("arst_no_rsp", 32'(cnt), 0);

        // Pointer back at 0: with 0 and 1 both valid, 0 wins first
        glog.delete();
        set_req(0, 4'd1, 4'd2, OP_OR);
        set_req(1, 4'd4, 4'd1, OP_LSL);
        req_valid[1:0] = 2'b11;
        wait_grant(0);
        req_valid[0] = 1'b0;
        drain();
        wait_grant(1);
        req_valid[1] = 1'b0;
        drain();
        check("arst_rr_ptr", (glog.size() > 0) ? 32'(glog[0]) : 32'hFFFF, 0);

`ifdef ALU_ARB_STATS_EN
        // ---------------- saturating statistics ----------------
        for (int k = 0; k < 300; k++) begin
            send(2, 4'(k), 4'd1, OP_ADD);
            drain();
        end
        check("stat_sat", 32'(stat_cnt[8*2 +: 8]), 255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d",
                 n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_alu_arbiter
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin scheduler that shares a single 4-bit ALU datapath between `NREQ` independent requesters. Each requester presents an operation over a valid/ready handshake; the arbiter grants one at a time, executes it on a registered ALU stage, and returns the result tagged with the requester index over a single backpressured response channel. It sits between the requesting units and the ALU and is the only block allowed to drive the ALU's operand and opcode inputs.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, $clog2(NREQ): width of the requester index.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept, one-hot or zero.
- `req_a`  in  4*NREQ  operand A, requester i at bits [4i+3:4i].
- `req_b`  in  4*NREQ  operand B, same packing.
- `req_op`  in  3*NREQ  opcode, requester i at bits [3i+2:3i].
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  IDW  index of the requester that owns the response.
- `rsp_result`  out  4  ALU result.
- `rsp_carry`  out  1  ALU carry.
- `stat_cnt`  out  8*NREQ  per-requester completed-op counters. Present only with `ALU_ARB_STATS_EN`.

## Operation
- There are three states: IDLE, EXEC and RESP.
- **IDLE**: if any `req_valid` is set, pick the winner by round-robin. The search starts at `rr_ptr` and wraps modulo NREQ. In the same cycle, assert `req_ready[winner]`, capture the winner's a, b and op plus its id, and go to EXEC. If no request is valid, stay in IDLE with `req_ready` = 0.
- **EXEC**: compute on the captured operands, register the result and carry, and go to RESP. `req_ready` is 0.
- **RESP**: `rsp_valid` = 1 and all response outputs are held stable. When `rsp_valid && rsp_ready`, set `rr_ptr` to (id+1) mod NREQ and go to IDLE. `req_ready` is 0.
- Opcodes (all 4-bit, results truncated to 4 bits):
  - 000 ADD: {carry,result} = a+b.
  - 001 SUB: {carry,result} = a + ~b + 1. Carry=1 means no borrow (a ≥ b).
  - 010 AND, 011 OR, 100 XOR: carry 0.
  - 101 NOT a (b ignored): carry 0.
  - 110 LSL: a << b[1:0], zero fill, carry 0.
  - 111 LSR: a >> b[1:0], zero fill, carry 0.
- Requesters must hold `req_valid` and their operands stable until `req_ready` is seen. Dropping `req_valid` before grant is legal; that request is simply not considered.
- Requests that arrive during EXEC or RESP wait. There is no queue.
- Reset values: state IDLE, `rr_ptr` 0, `req_ready` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_result` 0, `rsp_carry` 0, `stat_cnt` all 0.
- Reset asserted mid-operation discards the in-flight op. No response is produced for it.

## Timing
- `req_ready` is combinational from state, `req_valid` and `rr_ptr`. All other outputs come straight from registers.
- Grant is in cycle T. `rsp_valid` rises at the edge ending T+1, so it is visible in cycle T+2.
- The earliest next grant is the cycle after the response handshake. Peak throughput is one op per 3 cycles.
- A response handshake and a new request in the same cycle: the request is not granted until the following IDLE cycle.
- Round-robin applies only at grant. With all requesters continuously valid, grants go 0,1,2,…,NREQ-1,0.
- Backpressure: `rsp_ready` held low keeps the FSM in RESP indefinitely, with outputs stable.

## Configuration
- `ALU_ARB_STATS_EN` defined: add the `stat_cnt` port. Each 8-bit counter i increments on every response handshake with `rsp_id`==i and saturates at 255.
- Undefined: no port, no counter logic. Functional behaviour is otherwise identical.

## Structure
- Shared package `alu_arb_pkg`:
  - opcode localparams `OP_ADD`…`OP_LSR` (3'b000–3'b111);
  - state enum `IDLE`/`EXEC`/`RESP`.
- Sub-module `alu4_core`: purely combinational 4-bit ALU (a, b, op → result, carry) implementing the opcode table above. It is instantiated once and feeds the EXEC result register.

## Test plan
- Single request, req 1 ADD a=9 b=8 → `req_ready[1]` one cycle, then 2 cycles later `rsp_valid`, id=1, result=1, carry=1.
- SUB a=3 b=5 → result=14, carry=0. SUB a=5 b=3 → result=2, carry=1.
- All 4 requesters valid continuously, `rsp_ready`=1 → grant order 0,1,2,3,0, one response every 3 cycles.
- LSL a=4'b0111 b=2 → 4'b1100, carry 0. LSR a=4'b1000 b=3 → 4'b0001. NOT a=4'b1010 → 4'b0101.
- Hold `rsp_ready`=0 for 10 cycles in RESP → outputs stable, no `req_ready`. Release → handshake, return to IDLE.
- Assert `rst` during EXEC → all outputs 0 asynchronously, no response after release. With `ALU_ARB_STATS_EN`, 300 ops from req 2 → `stat_cnt[2]`=255.
